// File: rtl/arm_mul_unit_pkg.sv
// rtl/arm_mul_unit_pkg.sv - shared encodings, flag indices and FSM states for arm_mul_unit
//
// Contents:
//   MUL_OP_*      3-bit multiply opcodes ([2]=long, [1]=signed, [0]=accumulate)
//   NZCV_*        bit positions of N, Z, C, V in a 4-bit flag vector
//   mul_state_t   multiplier FSM states
//   mul_dec_t     decoded opcode fields
//   decode_op()   opcode -> decoded fields; short ops with the signed bit set
//                 decode as unsigned (the low WIDTH bits are identical)
package arm_mul_unit_pkg;

    localparam logic [2:0] MUL_OP_MUL   = 3'b000;
    localparam logic [2:0] MUL_OP_MLA   = 3'b001;
    localparam logic [2:0] MUL_OP_UMULL = 3'b100;
    localparam logic [2:0] MUL_OP_UMLAL = 3'b101;
    localparam logic [2:0] MUL_OP_SMULL = 3'b110;
    localparam logic [2:0] MUL_OP_SMLAL = 3'b111;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    typedef struct packed {
        logic is_long;
        logic is_signed;
        logic is_acc;
    } mul_dec_t;

    function automatic mul_dec_t decode_op(input logic [2:0] op);
        mul_dec_t d;
        d = '0;
        case (op)
            MUL_OP_MUL:   d = '0;
            MUL_OP_MLA:   d.is_acc = 1'b1;
            MUL_OP_UMULL: d.is_long = 1'b1;
            MUL_OP_UMLAL: begin
                d.is_long = 1'b1;
                d.is_acc  = 1'b1;
            end
            MUL_OP_SMULL: begin
                d.is_long   = 1'b1;
                d.is_signed = 1'b1;
            end
            MUL_OP_SMLAL: begin
                d.is_long   = 1'b1;
                d.is_signed = 1'b1;
                d.is_acc    = 1'b1;
            end
            default:      d.is_acc = op[0];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/arm_mul_unit_mul_step.sv
// rtl/arm_mul_unit_mul_step.sv - one multiplier iteration: chunk partial product, 2W add, signed correction
//
// Parameters: WIDTH (operand width), BITS_PER_CYCLE (chunk width B, power of two), CW (step index width)
// Ports:
//   acc       in   2*WIDTH  running accumulator
//   rm_ext    in   2*WIDTH  multiplicand, sign- or zero-extended
//   chunk     in   B        current unsigned multiplier chunk
//   step      in   CW       iteration index k
//   correct   in   1        subtract rm_ext << ((k+1)*B) (final iteration of a negative signed Rs)
//   acc_next  out  2*WIDTH  acc + rm_ext*chunk << k*B [- correction], mod 2^(2*WIDTH)
module arm_mul_unit_mul_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 8,
    parameter int CW             = 2
) (
    input  logic [2*WIDTH-1:0]        acc,
    input  logic [2*WIDTH-1:0]        rm_ext,
    input  logic [BITS_PER_CYCLE-1:0] chunk,
    input  logic [CW-1:0]             step,
    input  logic                      correct,
    output logic [2*WIDTH-1:0]        acc_next
);

    localparam int W2 = 2 * WIDTH;
    localparam int SW = $clog2(W2) + 1;
    localparam int LB = $clog2(BITS_PER_CYCLE);

    logic [SW-1:0] sh_lo;
    logic [SW-1:0] sh_hi;
    logic [W2-1:0] partial;
    logic [W2-1:0] correction;

    // B is a power of two, so k*B is a left shift of k.
    assign sh_lo      = SW'(step) << LB;
    assign sh_hi      = (SW'(step) + SW'(1)) << LB;
    assign partial    = rm_ext * W2'(chunk);
    assign correction = correct ? (rm_ext << sh_hi) : '0;
    assign acc_next   = acc + (partial << sh_lo) - correction;

endmodule

// File: rtl/arm_mul_unit.sv
// rtl/arm_mul_unit.sv - multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit, BITS_PER_CYCLE multiplier bits per cycle
//
// Optional feature: define MUL_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zeros (or all ones for signed ops).
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   start / in_ready            request; accepted when start & in_ready (IDLE or DONE)
//   mul_op[2:0]                 [2]=long, [1]=signed (long only), [0]=accumulate
//   set_flags                   S bit, latched at accept
//   operand_a / operand_b       Rm multiplicand / Rs multiplier
//   acc_lo / acc_hi             accumulator (acc_hi used by long ops only)
//   nzcv_in                     current flags; C,V are passed through
//   result_lo / result_hi       product (result_hi = 0 for short ops)
//   nzcv                        {N,Z,C,V} of the product
//   out_valid                   one-cycle completion pulse
//   result_writeback            = out_valid
//   hi_writeback                out_valid of a long op
//   nzcv_writeback              out_valid of an op with S set
module arm_mul_unit
    import arm_mul_unit_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             in_ready,
    input  logic [2:0]       mul_op,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [3:0]       nzcv_in,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       nzcv,
    output logic             out_valid,
    output logic             result_writeback,
    output logic             hi_writeback,
    output logic             nzcv_writeback
);

    localparam int W2    = 2 * WIDTH;
    localparam int K_MAX = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    mul_state_t state_q, state_d;

    logic [CW-1:0]    count_q;
    logic [W2-1:0]    acc_q;
    logic [W2-1:0]    rm_q;
    logic [WIDTH-1:0] rs_q;
    logic             signed_q;
    logic             rs_msb_q;
    logic             long_q;
    logic             flags_q;
    logic [1:0]       cv_q;

    mul_dec_t         dec;
    logic             accept;
    logic             last;
    logic             count_last;
    logic [W2-1:0]    acc_init;
    logic [W2-1:0]    rm_init;
    logic [W2-1:0]    acc_next;
    logic [WIDTH-1:0] rs_next;
    logic [3:0]       flags_d;
    logic             unused_flags_in;

    // N and Z come from the product; only C and V of the incoming flags matter.
    assign unused_flags_in = ^{nzcv_in[NZCV_N], nzcv_in[NZCV_Z]};

    assign dec      = decode_op(mul_op);
    assign in_ready = (state_q != ST_BUSY);
    assign accept   = start & in_ready;

    always_comb begin
        acc_init = '0;
        if (dec.is_acc) begin
            acc_init = dec.is_long ? {acc_hi, acc_lo} : W2'(acc_lo);
        end
    end

    assign rm_init = dec.is_signed ? {{WIDTH{operand_a[WIDTH-1]}}, operand_a}
                                   : {{WIDTH{1'b0}}, operand_a};

    // Rs is consumed low chunk first. Signed ops shift in copies of the sign
    // bit so the not-yet-consumed bits stay a faithful signed value.
    assign rs_next = signed_q ? WIDTH'($signed(rs_q) >>> BITS_PER_CYCLE)
                              : (rs_q >> BITS_PER_CYCLE);

    assign count_last = (count_q == CW'(K_MAX - 1));

`ifdef MUL_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_u;
    logic [WIDTH-1:0] rem_s;

    assign rem_u = rs_q >> BITS_PER_CYCLE;
    assign rem_s = WIDTH'($signed(rs_q) >>> BITS_PER_CYCLE);
    assign last  = count_last || (rem_u == '0) || (signed_q && (rem_s == '1));
`else
    assign last  = count_last;
`endif

    arm_mul_unit_mul_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .CW             (CW)
    ) u_step (
        .acc      (acc_q),
        .rm_ext   (rm_q),
        .chunk    (rs_q[BITS_PER_CYCLE-1:0]),
        .step     (count_q),
        .correct  (last & signed_q & rs_msb_q),
        .acc_next (acc_next)
    );

    always_comb begin
        flags_d         = '0;
        flags_d[NZCV_N] = long_q ? acc_next[W2-1] : acc_next[WIDTH-1];
        flags_d[NZCV_Z] = long_q ? (acc_next == '0) : (acc_next[WIDTH-1:0] == '0);
        flags_d[NZCV_C] = cv_q[1];
        flags_d[NZCV_V] = cv_q[0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_BUSY;
            ST_BUSY: if (last)  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_BUSY : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q        <= '0;
            acc_q          <= '0;
            rm_q           <= '0;
            rs_q           <= '0;
            signed_q       <= 1'b0;
            rs_msb_q       <= 1'b0;
            long_q         <= 1'b0;
            flags_q        <= 1'b0;
            cv_q           <= '0;
            result_lo      <= '0;
            result_hi      <= '0;
            nzcv           <= '0;
            out_valid      <= 1'b0;
            hi_writeback   <= 1'b0;
            nzcv_writeback <= 1'b0;
        end else begin
            out_valid      <= 1'b0;
            hi_writeback   <= 1'b0;
            nzcv_writeback <= 1'b0;
            if (accept) begin
                count_q  <= '0;
                acc_q    <= acc_init;
                rm_q     <= rm_init;
                rs_q     <= operand_b;
                signed_q <= dec.is_signed;
                rs_msb_q <= operand_b[WIDTH-1];
                long_q   <= dec.is_long;
                flags_q  <= set_flags;
                cv_q     <= {nzcv_in[NZCV_C], nzcv_in[NZCV_V]};
            end else if (state_q == ST_BUSY) begin
                count_q <= count_q + CW'(1);
                acc_q   <= acc_next;
                rs_q    <= rs_next;
                if (last) begin
                    // Writeback strobes are registered from the finishing op,
                    // so a back-to-back accept in DONE cannot disturb them.
                    out_valid      <= 1'b1;
                    result_lo      <= acc_next[WIDTH-1:0];
                    result_hi      <= long_q ? acc_next[W2-1:WIDTH] : '0;
                    nzcv           <= flags_d;
                    hi_writeback   <= long_q;
                    nzcv_writeback <= flags_q;
                end
            end
        end
    end

    assign result_writeback = out_valid;

endmodule
